// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the ARM data-processing
//               controller: FSM state encoding, ALU operation codes, ARM
//               opcode / condition-code values and instruction field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // ALU operation encodings driven on ALU_op
  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_CMP = 3'b010;
  localparam logic [2:0] c_ALU_AND = 3'b011;
  localparam logic [2:0] c_ALU_ORR = 3'b100;
  localparam logic [2:0] c_ALU_EOR = 3'b101;
  localparam logic [2:0] c_ALU_MOV = 3'b110;

  // ARM data-processing opcodes (instr[24:21])
  localparam logic [3:0] c_OPC_AND = 4'b0000;
  localparam logic [3:0] c_OPC_EOR = 4'b0001;
  localparam logic [3:0] c_OPC_SUB = 4'b0010;
  localparam logic [3:0] c_OPC_ADD = 4'b0100;
  localparam logic [3:0] c_OPC_CMP = 4'b1010;
  localparam logic [3:0] c_OPC_ORR = 4'b1100;
  localparam logic [3:0] c_OPC_MOV = 4'b1101;

  // ARM condition codes (instr[31:28])
  localparam logic [3:0] c_COND_EQ = 4'b0000;
  localparam logic [3:0] c_COND_NE = 4'b0001;
  localparam logic [3:0] c_COND_CS = 4'b0010;
  localparam logic [3:0] c_COND_CC = 4'b0011;
  localparam logic [3:0] c_COND_MI = 4'b0100;
  localparam logic [3:0] c_COND_PL = 4'b0101;
  localparam logic [3:0] c_COND_VS = 4'b0110;
  localparam logic [3:0] c_COND_VC = 4'b0111;
  localparam logic [3:0] c_COND_HI = 4'b1000;
  localparam logic [3:0] c_COND_LS = 4'b1001;
  localparam logic [3:0] c_COND_GE = 4'b1010;
  localparam logic [3:0] c_COND_LT = 4'b1011;
  localparam logic [3:0] c_COND_GT = 4'b1100;
  localparam logic [3:0] c_COND_LE = 4'b1101;
  localparam logic [3:0] c_COND_AL = 4'b1110;
  localparam logic [3:0] c_COND_NV = 4'b1111;

  // Instruction field bit positions
  localparam int c_COND_MSB  = 31;
  localparam int c_COND_LSB  = 28;
  localparam int c_I_BIT     = 25;
  localparam int c_OPC_MSB   = 24;
  localparam int c_OPC_LSB   = 21;
  localparam int c_S_BIT     = 20;
  localparam int c_RN_MSB    = 19;
  localparam int c_RN_LSB    = 16;
  localparam int c_RD_MSB    = 15;
  localparam int c_RD_LSB    = 12;
  localparam int c_RS_MSB    = 11;
  localparam int c_RS_LSB    = 8;
  localparam int c_SHAMT_MSB = 11;
  localparam int c_SHAMT_LSB = 7;
  localparam int c_SHOP_MSB  = 6;
  localparam int c_SHOP_LSB  = 5;
  localparam int c_SHREG_BIT = 4;
  localparam int c_RM_MSB    = 3;
  localparam int c_RM_LSB    = 0;
  localparam int c_IMM8_MSB  = 7;
  localparam int c_IMM8_LSB  = 0;

  // NZCV position inside status_out
  localparam int c_NZCV_MSB  = 31;
  localparam int c_NZCV_LSB  = 28;

endpackage
`default_nettype wire

// File: rtl/cpu_controller_cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Combinational ARM condition evaluation. Produces pass=1 when
//               the 4-bit cond field is satisfied by the NZCV flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = nzcv[3];
  assign w_z = nzcv[2];
  assign w_c = nzcv[1];
  assign w_v = nzcv[0];

  // Evaluate the condition code against the flags
  always_comb begin
    pass = 1'b0;
    case (cond)
      c_COND_EQ: pass = w_z;
      c_COND_NE: pass = ~w_z;
      c_COND_CS: pass = w_c;
      c_COND_CC: pass = ~w_c;
      c_COND_MI: pass = w_n;
      c_COND_PL: pass = ~w_n;
      c_COND_VS: pass = w_v;
      c_COND_VC: pass = ~w_v;
      c_COND_HI: pass = w_c & ~w_z;
      c_COND_LS: pass = ~w_c | w_z;
      c_COND_GE: pass = (w_n == w_v);
      c_COND_LT: pass = (w_n != w_v);
      c_COND_GT: pass = ~w_z & (w_n == w_v);
      c_COND_LE: pass = w_z | (w_n != w_v);
      c_COND_AL: pass = 1'b1;
      c_COND_NV: pass = 1'b0;
      default:   pass = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Multi-cycle controller for ARM data-processing instructions.
//               Sequences IDLE -> DECODE -> LOAD -> EXEC -> WB -> DONE and
//               drives register-read, shifter, ALU and write-back controls.
//               Optional macro COND_EXEC_EN enables condition-code checking
//               against status_out[31:28]; without it every decodable
//               instruction executes.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        done,
  input  logic [31:0] status_out,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_imme,
  output logic        sel_shift,
  output logic        sel_A,
  output logic        sel_B,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op,
  output logic        en_status,
  output logic        wb_sel,
  output logic [3:0]  w_addr,
  output logic        w_en
);

  state_t      r_state;
  logic [31:0] r_instr;

  logic [3:0]  w_opcode;
  logic        w_i;
  logic        w_s;
  logic [31:0] w_imm_ext;
  logic [4:0]  w_rot_amt;
  logic [31:0] w_imm_rot;
  logic [2:0]  w_alu_op;
  logic        w_decodable;
  logic        w_is_cmp;
  logic        w_is_mov;
  logic        w_cond_pass;
  logic        w_exec;

  assign w_opcode = r_instr[c_OPC_MSB:c_OPC_LSB];
  assign w_i      = r_instr[c_I_BIT];
  assign w_s      = r_instr[c_S_BIT];
  assign w_is_cmp = (w_opcode == c_OPC_CMP);
  assign w_is_mov = (w_opcode == c_OPC_MOV);

  // Immediate operand: imm8 rotated right by twice the 4-bit rotate field.
  // A left shift by 32 yields zero, so a zero rotation passes imm8 through.
  assign w_imm_ext = {24'd0, r_instr[c_IMM8_MSB:c_IMM8_LSB]};
  assign w_rot_amt = {r_instr[c_RS_MSB:c_RS_LSB], 1'b0};
  assign w_imm_rot = (w_imm_ext >> w_rot_amt) |
                     (w_imm_ext << (6'd32 - {1'b0, w_rot_amt}));

  // Map the ARM opcode onto the ALU operation; unsupported opcodes are skipped
  always_comb begin
    w_alu_op    = c_ALU_ADD;
    w_decodable = 1'b1;
    case (w_opcode)
      c_OPC_ADD: w_alu_op = c_ALU_ADD;
      c_OPC_SUB: w_alu_op = c_ALU_SUB;
      c_OPC_CMP: w_alu_op = c_ALU_CMP;
      c_OPC_AND: w_alu_op = c_ALU_AND;
      c_OPC_ORR: w_alu_op = c_ALU_ORR;
      c_OPC_EOR: w_alu_op = c_ALU_EOR;
      c_OPC_MOV: w_alu_op = c_ALU_MOV;
      default:   w_decodable = 1'b0;
    endcase
  end

  cond_check u_cond_check (
    .cond (r_instr[c_COND_MSB:c_COND_LSB]),
    .nzcv (status_out[c_NZCV_MSB:c_NZCV_LSB]),
    .pass (w_cond_pass)
  );

`ifdef COND_EXEC_EN
  assign w_exec = w_decodable & w_cond_pass;
  // Instruction and status bits that carry no meaning for this controller
  logic [29:0] w_unused_bits;
  assign w_unused_bits = {r_instr[27:26], status_out[27:0]};
`else
  // Condition field and flags are ignored in this build
  assign w_exec = w_decodable;
  logic [30:0] w_unused_bits;
  assign w_unused_bits = {w_cond_pass, r_instr[27:26], status_out[27:0]};
`endif

  // Sequencer with registered outputs; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_instr     <= 32'd0;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      A_addr      <= 4'd0;
      B_addr      <= 4'd0;
      shift_addr  <= 4'd0;
      en_A        <= 1'b0;
      en_B        <= 1'b0;
      en_S        <= 1'b0;
      shift_op    <= 2'd0;
      shift_imme  <= 32'd0;
      sel_shift   <= 1'b0;
      sel_A       <= 1'b0;
      sel_B       <= 1'b0;
      imme_data   <= 32'd0;
      ALU_op      <= 3'd0;
      en_status   <= 1'b0;
      wb_sel      <= 1'b0;
      w_addr      <= 4'd0;
      w_en        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_instr     <= instr;
            instr_ready <= 1'b0;
            r_state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_exec) begin
            r_state    <= ST_LOAD;
            A_addr     <= r_instr[c_RN_MSB:c_RN_LSB];
            B_addr     <= r_instr[c_RM_MSB:c_RM_LSB];
            shift_addr <= r_instr[c_RS_MSB:c_RS_LSB];
            en_A       <= 1'b1;
            en_B       <= ~w_i;
            en_S       <= ~w_i;
            sel_A      <= w_is_mov;
            sel_B      <= w_i;
            imme_data  <= w_i ? w_imm_rot : 32'd0;
            shift_op   <= w_i ? 2'd0 : r_instr[c_SHOP_MSB:c_SHOP_LSB];
            sel_shift  <= w_i ? 1'b0 : r_instr[c_SHREG_BIT];
            shift_imme <= w_i ? 32'd0 : {27'd0, r_instr[c_SHAMT_MSB:c_SHAMT_LSB]};
            ALU_op     <= w_alu_op;
          end else begin
            r_state <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_LOAD: begin
          en_A      <= 1'b0;
          en_B      <= 1'b0;
          en_S      <= 1'b0;
          en_status <= w_s | w_is_cmp;
          r_state   <= ST_EXEC;
        end
        ST_EXEC: begin
          en_status <= 1'b0;
          wb_sel    <= 1'b0;
          w_addr    <= r_instr[c_RD_MSB:c_RD_LSB];
          w_en      <= ~w_is_cmp;
          r_state   <= ST_WB;
        end
        ST_WB: begin
          // Retire: drop all datapath controls back to their idle values
          w_en       <= 1'b0;
          w_addr     <= 4'd0;
          A_addr     <= 4'd0;
          B_addr     <= 4'd0;
          shift_addr <= 4'd0;
          shift_op   <= 2'd0;
          shift_imme <= 32'd0;
          sel_shift  <= 1'b0;
          sel_A      <= 1'b0;
          sel_B      <= 1'b0;
          imme_data  <= 32'd0;
          ALU_op     <= 3'd0;
          done       <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          done        <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Self-checking bench for cpu_controller. Table of instruction
//               vectors with expected control values; expected per-cycle
//               output records are queued when an instruction is driven and
//               compared on the falling edge as the DUT steps through states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] status_out;
  logic        instr_ready, done;
  logic [3:0]  A_addr, B_addr, shift_addr;
  logic        en_A, en_B, en_S;
  logic [1:0]  shift_op;
  logic [31:0] shift_imme;
  logic        sel_shift, sel_A, sel_B;
  logic [31:0] imme_data;
  logic [2:0]  ALU_op;
  logic        en_status, wb_sel;
  logic [3:0]  w_addr;
  logic        w_en;

  cpu_controller dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .done(done), .status_out(status_out),
    .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
    .en_A(en_A), .en_B(en_B), .en_S(en_S),
    .shift_op(shift_op), .shift_imme(shift_imme), .sel_shift(sel_shift),
    .sel_A(sel_A), .sel_B(sel_B), .imme_data(imme_data), .ALU_op(ALU_op),
    .en_status(en_status), .wb_sel(wb_sel), .w_addr(w_addr), .w_en(w_en)
  );

  always #5 clk = ~clk;

`ifdef COND_EXEC_EN
  localparam bit c_COND = 1'b1;
`else
  localparam bit c_COND = 1'b0;
`endif

  typedef struct packed {
    logic        instr_ready;
    logic        done;
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic [3:0]  shift_addr;
    logic        en_a;
    logic        en_b;
    logic        en_s;
    logic [1:0]  shift_op;
    logic [31:0] shift_imme;
    logic        sel_shift;
    logic        sel_a;
    logic        sel_b;
    logic [31:0] imme_data;
    logic [2:0]  alu_op;
    logic        en_status;
    logic        wb_sel;
    logic [3:0]  w_addr;
    logic        w_en;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] status;
    bit          exec;
    logic [2:0]  alu;
    bit          sel_a;
    bit          sel_b;
    logic [31:0] imme;
    logic [1:0]  shop;
    bit          ssel;
    logic [31:0] shimm;
    bit          en_bs;
    bit          en_st;
    bit          wen;
  } vec_t;

  typedef struct {
    outs_t o;
    int    tag;
  } sb_t;

  sb_t   q[$];
  outs_t act;
  int    n_vec = 0;
  int    n_err = 0;

  always_comb begin
    act = '{instr_ready, done, A_addr, B_addr, shift_addr, en_A, en_B, en_S,
            shift_op, shift_imme, sel_shift, sel_A, sel_B, imme_data, ALU_op,
            en_status, wb_sel, w_addr, w_en};
  end

  task automatic check(input outs_t e, input int tag);
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL outputs tag=%0d at %0t: got %h expected %h", tag, $time, act, e);
    end
  endtask

  // Scoreboard consumer: one expected record per falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      sb_t s;
      s = q.pop_front();
      check(s.o, s.tag);
    end
  end

  // Expected outputs for a phase: 0 DECODE, 1 LOAD, 2 EXEC, 3 WB, 4 DONE, 5 IDLE
  function automatic outs_t exp_of(input vec_t v, input int ph);
    outs_t o;
    o = '0;
    if (ph == 5) o.instr_ready = 1'b1;
    if (ph == 4) o.done = 1'b1;
    if (ph >= 1 && ph <= 3) begin
      o.a_addr     = v.instr[19:16];
      o.b_addr     = v.instr[3:0];
      o.shift_addr = v.instr[11:8];
      o.sel_a      = v.sel_a;
      o.sel_b      = v.sel_b;
      o.imme_data  = v.imme;
      o.shift_op   = v.shop;
      o.sel_shift  = v.ssel;
      o.shift_imme = v.shimm;
      o.alu_op     = v.alu;
    end
    if (ph == 1) begin
      o.en_a = 1'b1;
      o.en_b = v.en_bs;
      o.en_s = v.en_bs;
    end
    if (ph == 2) o.en_status = v.en_st;
    if (ph == 3) begin
      o.w_addr = v.instr[15:12];
      o.w_en   = v.wen;
    end
    return o;
  endfunction

  task automatic push_seq(input vec_t v, input int tag, input int last_ph);
    sb_t s;
    s.tag = tag;
    for (int ph = 0; ph <= last_ph; ph++) begin
      if (v.exec || ph == 0 || ph >= 4) begin
        s.o = exp_of(v, ph);
        q.push_back(s);
      end
    end
  endtask

  task automatic wait_drain(input int tag);
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain tag=%0d: %0d records left, expected 0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = v.instr;
    status_out  = v.status;
    #1 push_seq(v, tag, 5);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_drain(tag);
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] st, input bit ex,
                              input logic [2:0] alu, input bit sa, input bit sb,
                              input logic [31:0] imm, input logic [1:0] shop, input bit ssel,
                              input logic [31:0] shimm, input bit enbs, input bit enst,
                              input bit wen);
    vec_t v;
    v.instr = ins; v.status = st; v.exec = ex; v.alu = alu; v.sel_a = sa;
    v.sel_b = sb; v.imme = imm; v.shop = shop; v.ssel = ssel; v.shimm = shimm;
    v.en_bs = enbs; v.en_st = enst; v.wen = wen;
    return v;
  endfunction

  vec_t vt[13];
  vec_t add_v;
  outs_t idle_o;

  initial begin
    //           instr         status        exec     alu   sA sB imme          sop ss shimm  bs st we
    vt[0]  = mk(32'hE0813002, 32'h0,        1'b1,    3'd0, 0, 0, 32'h0,        2'd0, 0, 32'd0,  1, 0, 1); // ADD r3,r1,r2
    vt[1]  = mk(32'hE3A0043F, 32'h0,        1'b1,    3'd6, 1, 1, 32'h3F000000, 2'd0, 0, 32'd0,  0, 0, 1); // MOV r0,#0x3F000000
    vt[2]  = mk(32'hE3510005, 32'h0,        1'b1,    3'd2, 0, 1, 32'h5,        2'd0, 0, 32'd0,  0, 1, 0); // CMP r1,#5
    vt[3]  = mk(32'hE25541FF, 32'h0,        1'b1,    3'd1, 0, 1, 32'hC000003F, 2'd0, 0, 32'd0,  0, 1, 1); // SUBS, wrap-around rotate
    vt[4]  = mk(32'hE00762A8, 32'h0,        1'b1,    3'd3, 0, 0, 32'h0,        2'd1, 0, 32'd5,  1, 0, 1); // AND, LSR #5
    vt[5]  = mk(32'hE19A9C5B, 32'h0,        1'b1,    3'd4, 0, 0, 32'h0,        2'd2, 1, 32'h18, 1, 1, 1); // ORRS, ASR by reg
    vt[6]  = mk(32'hE2232F12, 32'h0,        1'b1,    3'd5, 0, 1, 32'h48,       2'd0, 0, 32'd0,  0, 0, 1); // EOR, rotate 30
    vt[7]  = mk(32'hE1110002, 32'h0,        1'b0,    3'd0, 0, 0, 32'h0,        2'd0, 0, 32'd0,  0, 0, 0); // TST: not decodable
    vt[8]  = mk(32'h00813002, 32'h0,        !c_COND, 3'd0, 0, 0, 32'h0,        2'd0, 0, 32'd0,  1, 0, 1); // ADDEQ, Z=0
    vt[9]  = mk(32'h00813002, 32'h40000000, 1'b1,    3'd0, 0, 0, 32'h0,        2'd0, 0, 32'd0,  1, 0, 1); // ADDEQ, Z=1
    vt[10] = mk(32'hF0813002, 32'hF0000000, !c_COND, 3'd0, 0, 0, 32'h0,        2'd0, 0, 32'd0,  1, 0, 1); // never
    vt[11] = mk(32'hE1B05006, 32'h0,        1'b1,    3'd6, 1, 0, 32'h0,        2'd0, 0, 32'd0,  1, 1, 1); // MOVS r5,r6
    vt[12] = mk(32'hC0813002, 32'h80000000, !c_COND, 3'd0, 0, 0, 32'h0,        2'd0, 0, 32'd0,  1, 0, 1); // ADDGT, N!=V
    add_v  = vt[0];
    idle_o = '0;
    idle_o.instr_ready = 1'b1;

    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; status_out = 32'h0;
    #12 check(idle_o, 100);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) check(idle_o, 101);

    // Table-driven instructions
    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // instr_valid held high: exactly one accept per retirement
    @(negedge clk);
    instr_valid = 1'b1; instr = add_v.instr; status_out = 32'h0;
    #1 push_seq(add_v, 200, 5);
    wait_drain(200);
    push_seq(add_v, 201, 5);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_drain(201);

    // Reset asserted during EXEC aborts the instruction
    @(negedge clk);
    instr_valid = 1'b1; instr = add_v.instr;
    #1 push_seq(add_v, 300, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_drain(300);
    @(posedge clk);
    #2 check(exp_of(add_v, 2), 301);
    rst = 1'b1;
    #1 check(idle_o, 302);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) check(idle_o, 303 + i);
    end
    rst = 1'b0;
    @(negedge clk) check(idle_o, 306);

    // Normal operation resumes after reset
    run_vec(vt[2], 400);
    run_vec(add_v, 401);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
